// File: rtl/maze_level_sequencer_if.sv
// maze_level_sequencer_if: gameplay event inputs and renderer/status outputs of the level sequencer
//  startOfFrame  1  one-clock pulse per video frame
//  start_game    1  start key level; the sequencer detects its rising edge
//  level_done    1  player reached the exit
//  player_dead   1  player hit a hazard
//  surprise_hit  1  player took a surprise
//  level         3  current level, 1..LEVEL_NUM
//  draw_random   1  one-clock pulse asking the renderer for a new random map
//  empty_map     1  renderer shows the empty border map
//  lives         2  remaining lives
//  game_over     1  high while the game is lost
//  game_won      1  high while the game is won
interface maze_level_sequencer_if;
  logic       startOfFrame;
  logic       start_game;
  logic       level_done;
  logic       player_dead;
  logic       surprise_hit;
  logic [2:0] level;
  logic       draw_random;
  logic       empty_map;
  logic [1:0] lives;
  logic       game_over;
  logic       game_won;
  modport master (
    output startOfFrame, start_game, level_done, player_dead, surprise_hit,
    input  level, draw_random, empty_map, lives, game_over, game_won
  );
  modport slave (
    input  startOfFrame, start_game, level_done, player_dead, surprise_hit,
    output level, draw_random, empty_map, lives, game_over, game_won
  );
endinterface

// File: rtl/maze_level_sequencer.sv
// maze_level_sequencer: game-flow FSM producing level, draw_random, empty_map, lives and win/lose flags
//  clk     system clock
//  resetN  asynchronous active-low reset
//  bus     slave side of maze_level_sequencer_if (gameplay events in, renderer/status outputs out)
module maze_level_sequencer #(
  parameter int LEVEL_NUM       = 5,
  parameter int LIVES           = 3,
  parameter int INTER_FRAMES    = 60,
  parameter int SURPRISE_FRAMES = 30
) (
  input logic                   clk,
  input logic                   resetN,
  maze_level_sequencer_if.slave bus
);
  localparam int MAXF = INTER_FRAMES > SURPRISE_FRAMES ? INTER_FRAMES : SURPRISE_FRAMES;
  localparam int CW   = $clog2(MAXF + 1);
  typedef enum logic [2:0] {IDLE, NEW_MAP, PLAY, PAUSE, SURPRISE, WIN, LOSE} state_t;
  state_t          state, state_n;
  logic [2:0]      level, level_n;
  logic [1:0]      lives, lives_n;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc, cnt_lim;
  logic            start_q, armed, start_edge;
  logic            draw_random, empty_map, game_over, game_won;
  // armed stays low for the first cycle after reset so a key held through reset is not seen as an edge
  assign start_edge = bus.start_game & ~start_q & armed;
  assign cnt_inc    = (cnt == '1) ? cnt : cnt + CW'(bus.startOfFrame);
  assign cnt_lim    = (state == PAUSE) ? CW'(INTER_FRAMES) : CW'(SURPRISE_FRAMES);
  always_comb begin
    state_n = state;
    level_n = level;
    lives_n = lives;
    cnt_n   = '0;
    case (state)
      IDLE, WIN, LOSE: if (start_edge) begin
        state_n = NEW_MAP;
        level_n = 3'd1;
        lives_n = 2'(LIVES);
      end
      NEW_MAP: state_n = PLAY;
      PLAY: if (bus.player_dead) begin
        lives_n = (lives == 2'd0) ? lives : lives - 2'd1;
        state_n = (lives <= 2'd1) ? LOSE : PAUSE;
      end else if (bus.level_done) begin
        level_n = (level == 3'(LEVEL_NUM)) ? level : level + 3'd1;
        state_n = (level == 3'(LEVEL_NUM)) ? WIN : PAUSE;
      end else if (bus.surprise_hit) state_n = SURPRISE;
      // the counter is zero in every other state, so it starts cleared on entry
      PAUSE, SURPRISE: if (cnt_inc == cnt_lim) state_n = (state == PAUSE) ? NEW_MAP : PLAY;
                       else cnt_n = cnt_inc;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      level       <= 3'd1;
      lives       <= 2'(LIVES);
      cnt         <= '0;
      start_q     <= 1'b0;
      armed       <= 1'b0;
      draw_random <= 1'b0;
      empty_map   <= 1'b1;
      game_over   <= 1'b0;
      game_won    <= 1'b0;
    end else begin
      state       <= state_n;
      level       <= level_n;
      lives       <= lives_n;
      cnt         <= cnt_n;
      start_q     <= bus.start_game;
      armed       <= 1'b1;
      draw_random <= state_n == NEW_MAP;
      empty_map   <= !(state_n == NEW_MAP || state_n == PLAY);
      game_over   <= state_n == LOSE;
      game_won    <= state_n == WIN;
    end
  end
  assign bus.level       = level;
  assign bus.lives       = lives;
  assign bus.draw_random = draw_random;
  assign bus.empty_map   = empty_map;
  assign bus.game_over   = game_over;
  assign bus.game_won    = game_won;
endmodule

// File: tb/tb_maze_level_sequencer.sv
// tb_maze_level_sequencer: scenario tasks with an expected-output queue for maze_level_sequencer
module tb_maze_level_sequencer;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs, e;
  maze_level_sequencer_if bus();
  maze_level_sequencer dut (.clk(clk), .resetN(resetN), .bus(bus.slave));
  always #5 clk = ~clk;
  assign obs = {bus.level, bus.lives, bus.empty_map, bus.draw_random, bus.game_over, bus.game_won};
  function automatic logic [8:0] ex(int lv, int li, bit em, bit dr, bit ov, bit wn);
    return {3'(lv), 2'(li), em, dr, ov, wn};
  endfunction
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic frames(int n);
    for (int i = 0; i < n; i++) begin
      if (i != 0) tick();
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
    end
  endtask
  task automatic start_key();
    bus.start_game = 1'b1;
    tick();
    bus.start_game = 1'b0;
  endtask
  task automatic test_reset();
    exp_q.push_back(ex(1, 3, 1, 0, 0, 0));
    repeat (3) tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset got=%b want=%b", obs, e); end
    resetN = 1'b1;
    tick();
    exp_q.push_back(ex(1, 3, 1, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL idle_hold got=%b want=%b", obs, e); end
  endtask
  task automatic test_start();
    exp_q.push_back(ex(1, 3, 0, 1, 0, 0));
    start_key();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL start_draw got=%b want=%b", obs, e); end
    exp_q.push_back(ex(1, 3, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL start_play got=%b want=%b", obs, e); end
  endtask
  task automatic test_level_done();
    exp_q.push_back(ex(2, 3, 1, 0, 0, 0));
    bus.level_done = 1'b1;
    tick();
    bus.level_done = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL done_pause got=%b want=%b", obs, e); end
    exp_q.push_back(ex(2, 3, 1, 0, 0, 0));
    frames(59);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL pause_59 got=%b want=%b", obs, e); end
    exp_q.push_back(ex(2, 3, 0, 1, 0, 0));
    frames(1);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL pause_60_draw got=%b want=%b", obs, e); end
    exp_q.push_back(ex(2, 3, 0, 0, 0, 0));
    tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL pause_play got=%b want=%b", obs, e); end
  endtask
  task automatic test_lives();
    for (int k = 2; k >= 1; k--) begin
      exp_q.push_back(ex(2, k, 1, 0, 0, 0));
      bus.player_dead = 1'b1;
      tick();
      bus.player_dead = 1'b0;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL dead_pause lives=%0d got=%b want=%b", k, obs, e); end
      exp_q.push_back(ex(2, k, 0, 1, 0, 0));
      frames(60);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL dead_redraw lives=%0d got=%b want=%b", k, obs, e); end
      tick();
    end
    exp_q.push_back(ex(2, 0, 1, 0, 1, 0));
    bus.player_dead = 1'b1;
    tick();
    bus.player_dead = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL lose got=%b want=%b", obs, e); end
    exp_q.push_back(ex(2, 0, 1, 0, 1, 0));
    frames(70);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL lose_hold got=%b want=%b", obs, e); end
    exp_q.push_back(ex(1, 3, 0, 1, 0, 0));
    start_key();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL lose_restart got=%b want=%b", obs, e); end
    tick();
  endtask
  task automatic test_win();
    for (int l = 2; l <= 5; l++) begin
      exp_q.push_back(ex(l, 3, 1, 0, 0, 0));
      bus.level_done = 1'b1;
      tick();
      bus.level_done = 1'b0;
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL level_up to=%0d got=%b want=%b", l, obs, e); end
      frames(60);
      tick();
    end
    exp_q.push_back(ex(5, 3, 1, 0, 0, 1));
    bus.level_done = 1'b1;
    tick();
    bus.level_done = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL win got=%b want=%b", obs, e); end
    exp_q.push_back(ex(5, 3, 1, 0, 0, 1));
    frames(65);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL win_hold got=%b want=%b", obs, e); end
    exp_q.push_back(ex(1, 3, 0, 1, 0, 0));
    start_key();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL win_restart got=%b want=%b", obs, e); end
    tick();
  endtask
  task automatic test_priority_surprise();
    exp_q.push_back(ex(1, 2, 1, 0, 0, 0));
    bus.player_dead = 1'b1;
    bus.level_done = 1'b1;
    bus.surprise_hit = 1'b1;
    tick();
    bus.player_dead = 1'b0;
    bus.level_done = 1'b0;
    bus.surprise_hit = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL dead_over_done got=%b want=%b", obs, e); end
    frames(60);
    tick();
    exp_q.push_back(ex(2, 2, 1, 0, 0, 0));
    bus.level_done = 1'b1;
    bus.surprise_hit = 1'b1;
    tick();
    bus.level_done = 1'b0;
    bus.surprise_hit = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL done_over_surprise got=%b want=%b", obs, e); end
    frames(60);
    tick();
    exp_q.push_back(ex(2, 2, 1, 0, 0, 0));
    bus.surprise_hit = 1'b1;
    tick();
    bus.surprise_hit = 1'b0;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL surprise_enter got=%b want=%b", obs, e); end
    exp_q.push_back(ex(2, 2, 1, 0, 0, 0));
    frames(29);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL surprise_29 got=%b want=%b", obs, e); end
    exp_q.push_back(ex(2, 2, 0, 0, 0, 0));
    frames(1);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL surprise_exit got=%b want=%b", obs, e); end
    exp_q.push_back(ex(2, 2, 0, 0, 0, 0));
    bus.start_game = 1'b1;
    tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL start_ignored got=%b want=%b", obs, e); end
    bus.start_game = 1'b0;
    tick();
  endtask
  task automatic test_async_reset();
    exp_q.push_back(ex(3, 2, 1, 0, 0, 0));
    bus.level_done = 1'b1;
    tick();
    bus.level_done = 1'b0;
    frames(10);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL pre_reset got=%b want=%b", obs, e); end
    exp_q.push_back(ex(1, 3, 1, 0, 0, 0));
    #2 resetN = 1'b0;
    bus.start_game = 1'b1;
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL async_reset got=%b want=%b", obs, e); end
    tick();
    resetN = 1'b1;
    exp_q.push_back(ex(1, 3, 1, 0, 0, 0));
    repeat (4) tick();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL held_start got=%b want=%b", obs, e); end
    bus.start_game = 1'b0;
    tick();
    exp_q.push_back(ex(1, 3, 0, 1, 0, 0));
    start_key();
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL fresh_start got=%b want=%b", obs, e); end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
  initial begin
    bus.startOfFrame = 1'b0;
    bus.start_game = 1'b0;
    bus.level_done = 1'b0;
    bus.player_dead = 1'b0;
    bus.surprise_hit = 1'b0;
    test_reset();
    test_start();
    test_level_done();
    test_lives();
    test_win();
    test_priority_surprise();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
